// File: rtl/rx_udp_filt.sv
// -----------------------------------------------------------------------------
// rx_udp_filt
//   UDP receive parser for the byte stream that follows the IPv4 header.
//   Accumulates the 8-byte UDP header, matches the destination port against a
//   table of listening ports, strips the header and forwards the payload with
//   sop/eop markers. Trailing Ethernet padding is discarded. Emits a one-cycle
//   done pulse per accepted frame with error and checksum status.
//
//   Optional feature macro: UDP_CSUM_EN (ones-complement checksum check).
//
// Ports
//   RX_CLK        receive clock, rising edge
//   rst_n         asynchronous active-low reset
//   port_list     NUM_PORTS x 16-bit listening ports (entry i at [16i+15:16i])
//   port_en       per-entry enable
//   ph_sum        pre-folded pseudo-header sum (UDP_CSUM_EN only)
//   rx_data_v     frame byte valid, high for the whole frame
//   rx_data       frame byte
//   rx_src_port   source port of current/last accepted frame
//   rx_dst_port   destination port of current/last accepted frame
//   rx_port_idx   matched table index
//   rx_udp_data_v payload byte valid
//   rx_udp_data   payload byte
//   rx_udp_sop    first payload byte
//   rx_udp_eop    last payload byte
//   rx_udp_done   one-cycle frame completion pulse
//   rx_udp_err    with done: truncation or bad length
//   rx_csum_ok    with done: checksum result
// -----------------------------------------------------------------------------
module rx_udp_filt #(
    parameter int OCT       = 8,
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic                       RX_CLK,
    input  logic                       rst_n,
    input  logic [NUM_PORTS*OCT*2-1:0] port_list,
    input  logic [NUM_PORTS-1:0]       port_en,
    input  logic [OCT*2-1:0]           ph_sum,
    input  logic                       rx_data_v,
    input  logic [OCT-1:0]             rx_data,
    output logic [OCT*2-1:0]           rx_src_port,
    output logic [OCT*2-1:0]           rx_dst_port,
    output logic [IDX_W-1:0]           rx_port_idx,
    output logic                       rx_udp_data_v,
    output logic [OCT-1:0]             rx_udp_data,
    output logic                       rx_udp_sop,
    output logic                       rx_udp_eop,
    output logic                       rx_udp_done,
    output logic                       rx_udp_err,
    output logic                       rx_csum_ok
);
    localparam int W = OCT * 2;

    typedef enum logic [1:0] {HDR, PAY, DROP} state_t;

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_cnt;
    logic [W-1:0]    r_src;
    logic [OCT-1:0]  r_b2;
    logic [W-1:0]    r_len;
    logic [W-1:0]    r_rem;
    logic            r_match;
    logic            r_first;

    logic [W-1:0]    w_dst;
    logic            w_hit;
    logic [IDX_W-1:0] w_idx;
    logic            w_last;
    logic            w_done_nxt;
    logic            w_err_nxt;

    assign w_dst  = {r_b2, rx_data};
    assign w_last = (r_rem == W'(1));

    // Lowest enabled entry wins: scan downward so lower indices overwrite.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (port_en[i] && (port_list[i*W +: W] == w_dst)) begin
                w_hit = 1'b1;
                w_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge RX_CLK or negedge rst_n) begin
        if (!rst_n) r_state <= HDR;
        else        r_state <= w_state_nxt;
    end

    // Next state plus completion status. A registered eop always yields a
    // clean done on the following cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = rx_udp_eop;
        w_err_nxt   = 1'b0;
        if (!rx_data_v) begin
            w_state_nxt = HDR;
            if ((r_state == HDR && r_match && r_cnt >= 3'd4) || r_state == PAY) begin
                w_done_nxt = 1'b1;
                w_err_nxt  = 1'b1;
            end
        end else begin
            case (r_state)
                HDR: begin
                    if (r_cnt == 3'd7) begin
                        w_state_nxt = (r_match && r_len > W'(8)) ? PAY : DROP;
                        if (r_match && r_len <= W'(8)) begin
                            w_done_nxt = 1'b1;
                            w_err_nxt  = (r_len < W'(8));
                        end
                    end
                end
                PAY:     if (w_last) w_state_nxt = DROP;
                default: ;
            endcase
        end
    end

`ifdef UDP_CSUM_EN
    logic [W-1:0]   r_acc;
    logic [OCT-1:0] r_hi;
    logic           r_odd;
    logic [OCT-1:0] r_cs_hi;
    logic [W-1:0]   r_cs_fld;
    logic [W-1:0]   w_word;
    logic [W-1:0]   w_acc_add;
    logic           w_ok_nxt;

    function automatic logic [W-1:0] f_fold(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[W-1:0] + W'(s[W]);
    endfunction

    // Even-position byte is the word MSB; a lone final byte is zero-padded.
    assign w_word    = r_odd ? {r_hi, rx_data} : {rx_data, {OCT{1'b0}}};
    assign w_acc_add = f_fold(r_acc, w_word);

    always_comb begin
        w_ok_nxt = 1'b0;
        if (w_done_nxt && !w_err_nxt) begin
            if (rx_udp_eop) w_ok_nxt = (r_acc == '1) || (r_cs_fld == '0);
            else            w_ok_nxt = (w_acc_add == '1) || ({r_cs_hi, rx_data} == '0);
        end
    end

    always_ff @(posedge RX_CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_hi       <= '0;
            r_odd      <= 1'b0;
            r_cs_hi    <= '0;
            r_cs_fld   <= '0;
            rx_csum_ok <= 1'b0;
        end else begin
            rx_csum_ok <= w_ok_nxt;
            if (!rx_data_v) begin
                r_acc <= ph_sum;
                r_odd <= 1'b0;
            end else if (r_state == HDR || r_state == PAY) begin
                r_odd <= ~r_odd;
                if (r_odd || (r_state == PAY && w_last)) r_acc <= w_acc_add;
                else                                     r_hi  <= rx_data;
                if (r_state == HDR && r_cnt == 3'd6) r_cs_hi  <= rx_data;
                if (r_state == HDR && r_cnt == 3'd7) r_cs_fld <= {r_cs_hi, rx_data};
            end
        end
    end
`else
    logic w_unused_ph;
    assign w_unused_ph = ^ph_sum;
    assign rx_csum_ok  = 1'b1;
`endif

    always_ff @(posedge RX_CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_src         <= '0;
            r_b2          <= '0;
            r_len         <= '0;
            r_rem         <= '0;
            r_match       <= 1'b0;
            r_first       <= 1'b1;
            rx_src_port   <= '0;
            rx_dst_port   <= '0;
            rx_port_idx   <= '0;
            rx_udp_data_v <= 1'b0;
            rx_udp_data   <= '0;
            rx_udp_sop    <= 1'b0;
            rx_udp_eop    <= 1'b0;
            rx_udp_done   <= 1'b0;
            rx_udp_err    <= 1'b0;
        end else begin
            rx_udp_data_v <= 1'b0;
            rx_udp_sop    <= 1'b0;
            rx_udp_eop    <= 1'b0;
            rx_udp_done   <= w_done_nxt;
            rx_udp_err    <= w_err_nxt;
            if (!rx_data_v) begin
                r_cnt   <= '0;
                r_match <= 1'b0;
                r_first <= 1'b1;
            end else begin
                case (r_state)
                    HDR: begin
                        r_cnt <= r_cnt + 3'd1;
                        case (r_cnt)
                            3'd0: r_src[W-1:OCT] <= rx_data;
                            3'd1: r_src[OCT-1:0] <= rx_data;
                            3'd2: r_b2           <= rx_data;
                            3'd3: begin
                                // Table is sampled here only; output ports
                                // change only for accepted frames.
                                r_match <= w_hit;
                                if (w_hit) begin
                                    rx_src_port <= r_src;
                                    rx_dst_port <= w_dst;
                                    rx_port_idx <= w_idx;
                                end
                            end
                            3'd4: r_len[W-1:OCT] <= rx_data;
                            3'd5: r_len[OCT-1:0] <= rx_data;
                            3'd7: r_rem          <= r_len - W'(8);
                            default: ;
                        endcase
                    end
                    PAY: begin
                        rx_udp_data_v <= 1'b1;
                        rx_udp_data   <= rx_data;
                        rx_udp_sop    <= r_first;
                        rx_udp_eop    <= w_last;
                        r_first       <= 1'b0;
                        r_rem         <= r_rem - W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rx_udp_filt.sv
module tb_rx_udp_filt;
    localparam int OCT = 8, NUM_PORTS = 4, IDX_W = 2;

    logic                       RX_CLK = 1'b0;
    logic                       rst_n;
    logic [NUM_PORTS*OCT*2-1:0] port_list;
    logic [NUM_PORTS-1:0]       port_en;
    logic [15:0]                ph_sum;
    logic                       rx_data_v;
    logic [7:0]                 rx_data;
    logic [15:0]                rx_src_port, rx_dst_port;
    logic [IDX_W-1:0]           rx_port_idx;
    logic                       rx_udp_data_v, rx_udp_sop, rx_udp_eop;
    logic                       rx_udp_done, rx_udp_err, rx_csum_ok;
    logic [7:0]                 rx_udp_data;

    rx_udp_filt #(.OCT(OCT), .NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) dut (
        .RX_CLK(RX_CLK), .rst_n(rst_n), .port_list(port_list), .port_en(port_en),
        .ph_sum(ph_sum), .rx_data_v(rx_data_v), .rx_data(rx_data),
        .rx_src_port(rx_src_port), .rx_dst_port(rx_dst_port), .rx_port_idx(rx_port_idx),
        .rx_udp_data_v(rx_udp_data_v), .rx_udp_data(rx_udp_data),
        .rx_udp_sop(rx_udp_sop), .rx_udp_eop(rx_udp_eop), .rx_udp_done(rx_udp_done),
        .rx_udp_err(rx_udp_err), .rx_csum_ok(rx_csum_ok)
    );

    always #5 RX_CLK = ~RX_CLK;

    // Expected bundle: {data_v, data(8), sop, eop, done, err}
    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic [11:0] e;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [11:0] NONE     = 12'h000;
    localparam logic [11:0] DONE_OK  = 12'h002;
    localparam logic [11:0] DONE_ERR = 12'h003;

    function automatic logic [11:0] beat(input logic [7:0] d, input logic sop, input logic eop);
        return {1'b1, d, sop, eop, 2'b00};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        @(negedge RX_CLK);
        rx_data_v = v;
        rx_data   = d;
        @(posedge RX_CLK);
        #1;
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic [11:0] e);
        vec_t t;
        t.v = v; t.d = d; t.e = e;
        tbl.push_back(t);
    endtask

    task automatic hdr(input logic [15:0] src, input logic [15:0] dst,
                       input logic [15:0] len, input logic [15:0] cs, input logic [11:0] e7);
        add(1, src[15:8], NONE); add(1, src[7:0], NONE);
        add(1, dst[15:8], NONE); add(1, dst[7:0], NONE);
        add(1, len[15:8], NONE); add(1, len[7:0], NONE);
        add(1, cs[15:8],  NONE); add(1, cs[7:0],  e7);
    endtask

    task automatic run_tbl(input string tag);
        logic [11:0] act;
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d);
            act = {rx_udp_data_v, rx_udp_data_v ? rx_udp_data : 8'h00,
                   rx_udp_sop, rx_udp_eop, rx_udp_done, rx_udp_err};
            chk($sformatf("%s[%0d]", tag, i), {20'h0, act}, {20'h0, tbl[i].e});
        end
        tbl.delete();
    endtask

    // 3-byte payload frame to entry 1; payload 01 02 03 unless p0 overrides.
    task automatic csum_frame(input string tag, input logic [15:0] cs,
                              input logic [7:0] p0, input logic exp_ok);
        step(1, 8'h00); step(1, 8'h01); step(1, 8'h00); step(1, 8'h50);
        chk({tag, ".idx"}, {30'h0, rx_port_idx}, 32'd1);
        step(1, 8'h00); step(1, 8'h0B); step(1, cs[15:8]); step(1, cs[7:0]);
        step(1, p0);
        chk({tag, ".b0"}, {29'h0, rx_udp_data_v, rx_udp_sop, rx_udp_eop}, 32'b110);
        step(1, 8'h02);
        step(1, 8'h03);
        chk({tag, ".b2"}, {21'h0, rx_udp_data_v, rx_udp_data, rx_udp_sop, rx_udp_eop},
            {21'h0, 1'b1, 8'h03, 2'b01});
        step(1, 8'h00);
        chk({tag, ".done"}, {29'h0, rx_udp_done, rx_udp_err, rx_csum_ok},
            {29'h0, 1'b1, 1'b0, exp_ok});
        step(0, 8'h00);
    endtask

    initial begin
        rst_n     = 1'b0;
        rx_data_v = 1'b0;
        rx_data   = 8'h00;
        ph_sum    = 16'h1000;
        port_list = {16'h0050, 16'h0000, 16'h0050, 16'h1234};
        port_en   = 4'b1011;
        #3;
        chk("rst.outs", {24'h0, rx_udp_data_v, rx_udp_sop, rx_udp_eop, rx_udp_done,
                         rx_udp_err, rx_port_idx, 1'b0}, 32'h0);
        chk("rst.ports", {rx_src_port, rx_dst_port}, 32'h0);
        @(negedge RX_CLK);
        rst_n = 1'b1;

        // Normal frame: 4 payload bytes + 2 pad
        add(0, 8'h00, NONE);
        hdr(16'hABCD, 16'h1234, 16'h000C, 16'h0000, NONE);
        add(1, 8'hDE, beat(8'hDE, 1, 0)); add(1, 8'hAD, beat(8'hAD, 0, 0));
        add(1, 8'hBE, beat(8'hBE, 0, 0)); add(1, 8'hEF, beat(8'hEF, 0, 1));
        add(1, 8'h00, DONE_OK); add(1, 8'h00, NONE); add(0, 8'h00, NONE);
        run_tbl("frameA");
        chk("A.idx", {30'h0, rx_port_idx}, 32'd0);
        chk("A.ports", {rx_src_port, rx_dst_port}, 32'hABCD1234);

        // Unmatched destination: nothing out, ports retained
        hdr(16'h9999, 16'h5678, 16'h000C, 16'h0000, NONE);
        add(1, 8'hDE, NONE); add(1, 8'hAD, NONE); add(1, 8'hBE, NONE); add(1, 8'hEF, NONE);
        add(1, 8'h00, NONE); add(1, 8'h00, NONE); add(0, 8'h00, NONE);
        run_tbl("nomatch");
        chk("B.ports", {rx_src_port, rx_dst_port}, 32'hABCD1234);

        // len < 8, len == 8, len == 9
        hdr(16'h1111, 16'h1234, 16'h0005, 16'h0000, DONE_ERR);
        add(1, 8'h55, NONE); add(1, 8'h66, NONE); add(0, 8'h00, NONE);
        hdr(16'h2222, 16'h1234, 16'h0008, 16'h0000, DONE_OK);
        add(1, 8'h55, NONE); add(1, 8'h66, NONE); add(0, 8'h00, NONE);
        hdr(16'h3333, 16'h1234, 16'h0009, 16'h0000, NONE);
        add(1, 8'h77, beat(8'h77, 1, 1)); add(1, 8'h00, DONE_OK); add(0, 8'h00, NONE);
        run_tbl("len");

        // Truncation in payload, after byte 3, before byte 3, unmatched
        hdr(16'h4444, 16'h1234, 16'h0010, 16'h0000, NONE);
        add(1, 8'h11, beat(8'h11, 1, 0)); add(1, 8'h22, beat(8'h22, 0, 0));
        add(1, 8'h33, beat(8'h33, 0, 0)); add(0, 8'h00, DONE_ERR); add(0, 8'h00, NONE);
        add(1, 8'h01, NONE); add(1, 8'h02, NONE); add(1, 8'h12, NONE); add(1, 8'h34, NONE);
        add(0, 8'h00, DONE_ERR);
        add(1, 8'h01, NONE); add(1, 8'h02, NONE); add(1, 8'h12, NONE); add(0, 8'h00, NONE);
        add(1, 8'h01, NONE); add(1, 8'h02, NONE); add(1, 8'h56, NONE); add(1, 8'h78, NONE);
        add(1, 8'h00, NONE); add(0, 8'h00, NONE);
        run_tbl("trunc");
        chk("T.src", {16'h0, rx_src_port}, 32'h00000102);

        // Lowest matching index wins, then async reset mid-payload
        step(1, 8'h00); step(1, 8'h07); step(1, 8'h00); step(1, 8'h50);
        chk("E.idx", {30'h0, rx_port_idx}, 32'd1);
        step(1, 8'h00); step(1, 8'h10); step(1, 8'h00); step(1, 8'h00);
        step(1, 8'hA1); step(1, 8'hA2);
        chk("E.beat", {23'h0, rx_udp_data_v, rx_udp_data}, {23'h0, 1'b1, 8'hA2});
        @(negedge RX_CLK);
        rx_data = 8'hA3;
        #2 rst_n = 1'b0;
        #1;
        chk("E.rst.outs", {24'h0, rx_udp_data_v, rx_udp_sop, rx_udp_eop, rx_udp_done,
                           rx_udp_err, rx_port_idx, 1'b0}, 32'h0);
        chk("E.rst.ports", {rx_src_port, rx_dst_port}, 32'h0);
        chk("E.rst.data", {24'h0, rx_udp_data}, 32'h0);
        @(negedge RX_CLK);
        rx_data_v = 1'b0;
        rst_n     = 1'b1;
        @(posedge RX_CLK);
        #1;

        // Checksum: valid, corrupted payload bit, zero checksum field
        csum_frame("cs.good", 16'hEBA1, 8'h01, 1'b1);
`ifdef UDP_CSUM_EN
        csum_frame("cs.bad", 16'hEBA1, 8'h00, 1'b0);
`else
        csum_frame("cs.bad", 16'hEBA1, 8'h00, 1'b1);
`endif
        csum_frame("cs.zero", 16'h0000, 8'h00, 1'b1);
        chk("cs.ports", {rx_src_port, rx_dst_port}, 32'h00010050);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
